// File: rtl/core_bus_arb_pkg.sv
// Shared core types and arbiter defaults (package i2d_core_defines).
package i2d_core_defines;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IF,
      ARB_MEM
   } arb_state_t;

   localparam int unsigned ARB_MAX_BURST_DEF = 8;
   localparam int unsigned ARB_TIMEOUT_DEF   = 64;
   localparam logic [31:0] ARB_ABORT_DAT     = 32'hDEAD_BEEF;

endpackage

// File: rtl/core_bus_arb_wdog.sv
// Bus watchdog for core_bus_arb: flags a transfer stalled for TIMEOUT cycles.
// Only present when CORE_BUS_ARB_TIMEOUT_EN is defined.
`ifdef CORE_BUS_ARB_TIMEOUT_EN
module core_bus_arb_wdog
   import i2d_core_defines::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic stb,
   input  logic ack,
   input  logic clr,
   output logic fire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Fires on the TIMEOUT-th consecutive stalled strobe cycle.
   assign fire = stb & ~ack & (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr || ack || fire) begin
         cnt_d = '0;
      end else if (stb) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/core_bus_arb.sv
// Two-master Wishbone arbiter (IF vs MEM) with registered grant, MEM priority and
// a burst limit. Define CORE_BUS_ARB_TIMEOUT_EN to add the stalled-slave watchdog.
module core_bus_arb
   import i2d_core_defines::*;
#(
   parameter int unsigned AW        = $bits(addr_t),
   parameter int unsigned DW        = $bits(instr_t),
   parameter int unsigned MAX_BURST = ARB_MAX_BURST_DEF
`ifdef CORE_BUS_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT   = ARB_TIMEOUT_DEF
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_cyc,
   input  logic          if_stb,
   input  logic [AW-1:0] if_adr,
   output logic          if_ack,
   output logic [DW-1:0] if_dat,
   input  logic          mem_cyc,
   input  logic          mem_stb,
   input  logic          mem_we,
   input  logic [3:0]    mem_sel,
   input  logic [AW-1:0] mem_adr,
   input  logic [DW-1:0] mem_dat_w,
   output logic          mem_ack,
   output logic [DW-1:0] mem_dat,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   output logic [3:0]    wb_sel,
   output logic [AW-1:0] wb_adr,
   output logic [DW-1:0] wb_dat_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack
`ifdef CORE_BUS_ARB_TIMEOUT_EN
   ,
   input  logic          wb_err,
   output logic          arb_err
`endif
);

   arb_state_t state_q, state_d, other;
   logic [7:0] burst_cnt_q, burst_cnt_d, burst_inc;
   logic       own_cyc, oth_cyc, abort;

`ifdef CORE_BUS_ARB_TIMEOUT_EN
   logic tmo;

   core_bus_arb_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk (clk),
      .rst (rst),
      .stb (wb_stb),
      .ack (wb_ack),
      .clr (state_d != state_q),
      .fire(tmo)
   );

   assign abort   = (state_q != ARB_IDLE) & (tmo | wb_err);
   assign arb_err = abort;
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      burst_inc   = burst_cnt_q + 8'd1;
      own_cyc     = 1'b0;
      oth_cyc     = 1'b0;
      other       = ARB_IDLE;
      unique case (state_q)
         ARB_IF: begin
            own_cyc = if_cyc;
            oth_cyc = mem_cyc;
            other   = ARB_MEM;
         end
         ARB_MEM: begin
            own_cyc = mem_cyc;
            oth_cyc = if_cyc;
            other   = ARB_IF;
         end
         default: ;
      endcase

      if (state_q == ARB_IDLE) begin
         burst_cnt_d = '0;
         if (mem_cyc) begin
            state_d = ARB_MEM;
         end else if (if_cyc) begin
            state_d = ARB_IF;
         end
      end else if (abort || !own_cyc) begin
         state_d     = ARB_IDLE;
         burst_cnt_d = '0;
      end else if (!oth_cyc) begin
         burst_cnt_d = '0;
      end else if (wb_ack) begin
         // Limit reached on this beat: the ack still goes out, the grant flips next cycle.
         if (burst_inc == 8'(MAX_BURST)) begin
            state_d     = other;
            burst_cnt_d = '0;
         end else begin
            burst_cnt_d = burst_inc;
         end
      end
   end

   always_comb begin
      wb_cyc   = 1'b0;
      wb_stb   = 1'b0;
      wb_we    = 1'b0;
      wb_sel   = 4'h0;
      wb_adr   = '0;
      wb_dat_o = '0;
      if_ack   = 1'b0;
      if_dat   = '0;
      mem_ack  = 1'b0;
      mem_dat  = '0;
      unique case (state_q)
         ARB_IF: begin
            wb_cyc = if_cyc;
            wb_stb = if_stb;
            wb_sel = 4'hF;
            wb_adr = if_adr;
            if_ack = wb_ack;
            if_dat = wb_dat_i;
            if (abort) begin
               if_ack = 1'b1;
               if_dat = DW'(ARB_ABORT_DAT);
            end
         end
         ARB_MEM: begin
            wb_cyc   = mem_cyc;
            wb_stb   = mem_stb;
            wb_we    = mem_we;
            wb_sel   = mem_sel;
            wb_adr   = mem_adr;
            wb_dat_o = mem_dat_w;
            mem_ack  = wb_ack;
            mem_dat  = wb_dat_i;
            if (abort) begin
               mem_ack = 1'b1;
               mem_dat = DW'(ARB_ABORT_DAT);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_core_bus_arb.sv
// Self-checking bench for core_bus_arb: bench-side slave pushes expected acks to a
// scoreboard that a negedge monitor pops as acks reach the requesters.
module tb_core_bus_arb;

   logic        clk, rst;
   logic        if_cyc, if_stb, if_ack;
   logic [31:0] if_adr, if_dat;
   logic        mem_cyc, mem_stb, mem_we, mem_ack;
   logic [3:0]  mem_sel;
   logic [31:0] mem_adr, mem_dat_w, mem_dat;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
   logic        wb_err, arb_err;
`endif

   core_bus_arb dut (
      .clk      (clk),
      .rst      (rst),
      .if_cyc   (if_cyc),
      .if_stb   (if_stb),
      .if_adr   (if_adr),
      .if_ack   (if_ack),
      .if_dat   (if_dat),
      .mem_cyc  (mem_cyc),
      .mem_stb  (mem_stb),
      .mem_we   (mem_we),
      .mem_sel  (mem_sel),
      .mem_adr  (mem_adr),
      .mem_dat_w(mem_dat_w),
      .mem_ack  (mem_ack),
      .mem_dat  (mem_dat),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_sel   (wb_sel),
      .wb_adr   (wb_adr),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack   (wb_ack)
`ifdef CORE_BUS_ARB_TIMEOUT_EN
      ,
      .wb_err   (wb_err),
      .arb_err  (arb_err)
`endif
   );

   typedef struct packed {
      logic        is_mem;
      logic [31:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_ack(input logic is_mem, input logic [31:0] d);
      exp_t e;
      e.is_mem = is_mem;
      e.dat    = d;
      wb_ack   = 1'b1;
      wb_dat_i = d;
      sb_q.push_back(e);
   endtask

   task automatic drop_all();
      if_cyc  = 1'b0;
      if_stb  = 1'b0;
      mem_cyc = 1'b0;
      mem_stb = 1'b0;
      mem_we  = 1'b0;
      wb_ack  = 1'b0;
   endtask

   // Scoreboard monitor: every forwarded ack must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && (if_ack || mem_ack)) begin
         check_eq("ack_onehot", 32'(if_ack & mem_ack), 32'd0);
         if (sb_q.size() == 0) begin
            check_eq("ack_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("ack_route", 32'(mem_ack), 32'(e.is_mem));
            check_eq("ack_data", mem_ack ? mem_dat : if_dat, e.dat);
         end
      end
   end

   initial begin
      rst       = 1'b0;
      if_adr    = '0;
      mem_sel   = 4'h0;
      mem_adr   = '0;
      mem_dat_w = '0;
      wb_dat_i  = '0;
`ifdef CORE_BUS_ARB_TIMEOUT_EN
      wb_err    = 1'b0;
`endif
      drop_all();

      // Reset state
      repeat (3) tick();
      check_eq("rst_wb_cyc", 32'(wb_cyc), 32'd0);
      check_eq("rst_if_ack", 32'(if_ack), 32'd0);
      check_eq("rst_mem_dat", mem_dat, 32'd0);

      // IF alone: grant one cycle after request
      rst    = 1'b1;
      if_cyc = 1'b1;
      if_stb = 1'b1;
      if_adr = 32'h40;
      @(negedge clk);
      check_eq("if_req_wb_cyc_n", 32'(wb_cyc), 32'd0);
      tick();
      check_eq("if_grant_cyc", 32'(wb_cyc), 32'd1);
      check_eq("if_grant_adr", wb_adr, 32'h40);
      check_eq("if_grant_sel", 32'(wb_sel), 32'hF);
      check_eq("if_grant_we", 32'(wb_we), 32'd0);
      slave_ack(1'b0, 32'h1234);
      @(negedge clk);
      check_eq("if_ack_mem_ack", 32'(mem_ack), 32'd0);
      check_eq("if_ack_mem_dat", mem_dat, 32'd0);
      tick();
      drop_all();
      @(negedge clk);
      check_eq("if_release_cyc", 32'(wb_cyc), 32'd0);
      tick();

      // Simultaneous request: MEM wins
      if_cyc    = 1'b1;
      if_stb    = 1'b1;
      if_adr    = 32'h200;
      mem_cyc   = 1'b1;
      mem_stb   = 1'b1;
      mem_we    = 1'b1;
      mem_sel   = 4'h3;
      mem_adr   = 32'h100;
      mem_dat_w = 32'hA5A5_A5A5;
      tick();
      check_eq("both_adr", wb_adr, 32'h100);
      check_eq("both_we", 32'(wb_we), 32'd1);
      check_eq("both_sel", 32'(wb_sel), 32'h3);
      check_eq("both_dat_o", wb_dat_o, 32'hA5A5_A5A5);
      slave_ack(1'b1, 32'h55);
      @(negedge clk);
      check_eq("both_if_ack", 32'(if_ack), 32'd0);
      tick();
      drop_all();
      tick();
      tick();

      // Burst limit: MEM continuous, IF waiting
      mem_cyc = 1'b1;
      mem_stb = 1'b1;
      mem_sel = 4'hF;
      mem_adr = 32'h300;
      if_cyc  = 1'b1;
      if_stb  = 1'b1;
      if_adr  = 32'h400;
      tick();
      for (int i = 0; i < 8; i++) begin
         slave_ack(1'b1, 32'h1000 + 32'(i));
         @(negedge clk);
         check_eq("burst_mem_adr", wb_adr, 32'h300);
         tick();
      end
      wb_ack = 1'b0;
      @(negedge clk);
      check_eq("burst_switch_adr", wb_adr, 32'h400);
      check_eq("burst_switch_we", 32'(wb_we), 32'd0);
      check_eq("burst_switch_mem_ack", 32'(mem_ack), 32'd0);
      tick();
      slave_ack(1'b0, 32'h2000);
      tick();
      drop_all();
      tick();
      tick();

      // IF holds bus through a delayed ack while MEM waits
      if_cyc  = 1'b1;
      if_stb  = 1'b1;
      if_adr  = 32'h500;
      tick();
      mem_cyc = 1'b1;
      mem_stb = 1'b1;
      mem_we  = 1'b0;
      mem_adr = 32'h600;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("stall_hold_adr", wb_adr, 32'h500);
         tick();
      end
      slave_ack(1'b0, 32'h3000);
      tick();
      wb_ack = 1'b0;
      @(negedge clk);
      check_eq("post_ack_keep_adr", wb_adr, 32'h500);
      tick();
      if_cyc = 1'b0;
      if_stb = 1'b0;
      @(negedge clk);
      check_eq("if_drop_cyc", 32'(wb_cyc), 32'd0);
      tick();
      tick();
      check_eq("mem_after_if_cyc", 32'(wb_cyc), 32'd1);
      check_eq("mem_after_if_adr", wb_adr, 32'h600);

      // Asynchronous reset mid-transfer
      rst      = 1'b0;
      wb_ack   = 1'b1;
      wb_dat_i = 32'hBAD0_0001;
      #1;
      check_eq("arst_wb_cyc", 32'(wb_cyc), 32'd0);
      check_eq("arst_wb_adr", wb_adr, 32'd0);
      check_eq("arst_wb_stb", 32'(wb_stb), 32'd0);
      check_eq("arst_mem_ack", 32'(mem_ack), 32'd0);
      drop_all();
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_eq("arst_idle_cyc", 32'(wb_cyc), 32'd0);
      tick();
      if_cyc = 1'b1;
      if_stb = 1'b1;
      if_adr = 32'h800;
      @(negedge clk);
      check_eq("arst_regrant_n", 32'(wb_cyc), 32'd0);
      tick();
      check_eq("arst_regrant_adr", wb_adr, 32'h800);
      drop_all();
      tick();
      tick();

`ifdef CORE_BUS_ARB_TIMEOUT_EN
      begin
         exp_t e;
         bit   seen;
         int   k;
         seen     = 1'b0;
         k        = 0;
         e.is_mem = 1'b0;
         e.dat    = 32'hDEAD_BEEF;
         sb_q.push_back(e);
         if_cyc = 1'b1;
         if_stb = 1'b1;
         if_adr = 32'h700;
         tick();
         for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (arb_err) begin
               seen = 1'b1;
               k    = c;
               check_eq("tmo_if_ack", 32'(if_ack), 32'd1);
               check_eq("tmo_if_dat", if_dat, 32'hDEAD_BEEF);
            end
            tick();
         end
         check_eq("tmo_cycle", 32'(k), 32'd64);
         @(negedge clk);
         check_eq("tmo_idle_cyc", 32'(wb_cyc), 32'd0);
         check_eq("tmo_err_pulse", 32'(arb_err), 32'd0);
         drop_all();
         tick();
      end
`endif

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
